// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register-tag width, PC index, forwarding encodings,
// the shadow-stage records and the operand forwarding priority rule.
package pipe_pkg;

    localparam int RA_W = 4;
    localparam logic [RA_W-1:0] PC_REG = RA_W'(15);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] wa;
        logic            rw;
        logic            ld;
        logic            pcs;
        logic [RA_W-1:0] ra1;
        logic [RA_W-1:0] ra2;
    } e_stage_t;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] wa;
        logic            rw;
        logic            pcs;
    } m_stage_t;

    // A PC write sitting in W no longer holds fetch, so W keeps no pcs flag.
    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] wa;
        logic            rw;
    } w_stage_t;

    // The PC is never forwarded; the younger (M) producer wins over W.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                           input logic m_wr, input logic [RA_W-1:0] m_wa,
                                           input logic w_wr, input logic [RA_W-1:0] w_wa);
        if (src == PC_REG)            return FWD_RF;
        if (m_wr && (m_wa == src))    return FWD_M;
        if (w_wr && (w_wa == src))    return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage instruction tags in, pipeline-register enables, forward selects and
// debug counters out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    import pipe_pkg::*;

    logic            ValidD;
    logic [RA_W-1:0] Ra1D;
    logic [RA_W-1:0] Ra2D;
    logic [RA_W-1:0] WA3D;
    logic            RegWriteD;
    logic            MemtoRegD;
    logic            PCSrcD;
    logic            BranchTakenE;
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output ValidD, Ra1D, Ra2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt, FlushCnt
    );

    modport slave (
        input  ValidD, Ra1D, Ra2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt, FlushCnt
    );

endinterface

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: shadows E/M/W tags, resolves load-use,
// taken-branch and PC-write hazards and picks E-stage operand forwarding.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    e_stage_t e_st;
    m_stage_t m_st;
    w_stage_t w_st;

    logic run;
    logic m_wr, w_wr;
    logic ld_stall, pc_wr;
    logic stall_d, flush_e;

    // Outputs are held at zero while reset is asserted, whatever the inputs do.
    assign run  = reset;
    assign m_wr = m_st.v & m_st.rw;
    assign w_wr = w_st.v & w_st.rw;

    assign ld_stall = e_st.v & e_st.rw & e_st.ld & hz.ValidD &
                      ((e_st.wa == hz.Ra1D) | (e_st.wa == hz.Ra2D)) &
                      (e_st.wa != PC_REG);
    assign pc_wr    = (hz.ValidD & hz.PCSrcD) | (e_st.v & e_st.pcs) | (m_st.v & m_st.pcs);

    // A taken branch squashes D, so it must be flushed rather than held.
    assign stall_d = run & ld_stall & ~hz.BranchTakenE;
    assign flush_e = run & (ld_stall | hz.BranchTakenE);

    assign hz.StallD    = stall_d;
    assign hz.StallF    = stall_d | (run & pc_wr);
    assign hz.FlushE    = flush_e;
    assign hz.FlushD    = run & (hz.BranchTakenE | pc_wr);
    assign hz.ForwardAE = run ? fwd_sel(e_st.ra1, m_wr, m_st.wa, w_wr, w_st.wa) : FWD_RF;
    assign hz.ForwardBE = run ? fwd_sel(e_st.ra2, m_wr, m_st.wa, w_wr, w_st.wa) : FWD_RF;

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_st <= '0;
            m_st <= '0;
            w_st <= '0;
        end else begin
            if (flush_e)
                e_st <= '0;
            else
                e_st <= '{v: hz.ValidD, wa: hz.WA3D, rw: hz.RegWriteD, ld: hz.MemtoRegD,
                          pcs: hz.PCSrcD, ra1: hz.Ra1D, ra2: hz.Ra2D};
            m_st <= '{v: e_st.v, wa: e_st.wa, rw: e_st.rw, pcs: e_st.pcs};
            w_st <= '{v: m_st.v, wa: m_st.wa, rw: m_st.rw};
        end
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_d), .cnt(hz.StallCnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(flush_e), .cnt(hz.FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, counter saturation sequence and
// randomized traffic against an in-flight-instruction reference model.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // currently driven inputs
    bit       c_rst, c_v, c_rw, c_ld, c_pcs, c_bt;
    logic [3:0] c_ra1, c_ra2, c_wa;

    // reference model: instructions in flight, index 0=E, 1=M, 2=W
    typedef struct {
        bit v; int wa; bit rw; bit ld; bit pcs; int ra1; int ra2;
    } ins_t;
    typedef struct {
        bit sf; bit sd; bit fd; bit fe; int fa; int fb;
    } out_t;

    ins_t flight[3];
    int   m_scnt, m_fcnt;

    function automatic int model_fwd(input int src);
        if (src == 15) return 0;
        for (int k = 1; k <= 2; k++)
            if (flight[k].v && flight[k].rw && flight[k].wa == src)
                return (k == 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic out_t model_out();
        out_t o;
        bit ldu, pcw;
        o = '{0, 0, 0, 0, 0, 0};
        if (!c_rst) return o;
        ldu = flight[0].v && flight[0].rw && flight[0].ld && c_v && flight[0].wa != 15 &&
              (flight[0].wa == int'(c_ra1) || flight[0].wa == int'(c_ra2));
        pcw = (c_v && c_pcs) || (flight[0].v && flight[0].pcs) || (flight[1].v && flight[1].pcs);
        o.sd = ldu && !c_bt;
        o.sf = o.sd || pcw;
        o.fe = ldu || c_bt;
        o.fd = c_bt || pcw;
        o.fa = model_fwd(flight[0].ra1);
        o.fb = model_fwd(flight[0].ra2);
        return o;
    endfunction

    // advance the model across one clock edge using the inputs now driven
    task automatic model_step();
        out_t o;
        ins_t nop;
        nop = '{0, 0, 0, 0, 0, 0, 0};
        o = model_out();
        if (!c_rst) begin
            flight[0] = nop; flight[1] = nop; flight[2] = nop;
            m_scnt = 0; m_fcnt = 0;
        end else begin
            if (o.sd && m_scnt < SAT) m_scnt++;
            if (o.fe && m_fcnt < SAT) m_fcnt++;
            flight[2] = flight[1];
            flight[1] = flight[0];
            flight[0] = o.fe ? nop : '{c_v, int'(c_wa), c_rw, c_ld, c_pcs, int'(c_ra1), int'(c_ra2)};
        end
    endtask

    task automatic apply(input bit r, input bit v, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] w, input bit rw, input bit ld, input bit pcs,
                         input bit bt);
        @(posedge clk);
        model_step();
        #1;
        c_rst = r; c_v = v; c_ra1 = a1; c_ra2 = a2; c_wa = w;
        c_rw = rw; c_ld = ld; c_pcs = pcs; c_bt = bt;
        reset = r; hz.ValidD = v; hz.Ra1D = a1; hz.Ra2D = a2; hz.WA3D = w;
        hz.RegWriteD = rw; hz.MemtoRegD = ld; hz.PCSrcD = pcs; hz.BranchTakenE = bt;
        #1;
    endtask

    task automatic idle();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit sf, input bit sd, input bit fd,
                             input bit fe, input int fa, input int fb,
                             input bit do_cnt, input int sc, input int fc);
        chk({tag, ".StallF"}, 32'(hz.StallF), 32'(sf));
        chk({tag, ".StallD"}, 32'(hz.StallD), 32'(sd));
        chk({tag, ".FlushD"}, 32'(hz.FlushD), 32'(fd));
        chk({tag, ".FlushE"}, 32'(hz.FlushE), 32'(fe));
        chk({tag, ".ForwardAE"}, 32'(hz.ForwardAE), 32'(fa));
        chk({tag, ".ForwardBE"}, 32'(hz.ForwardBE), 32'(fb));
        if (do_cnt) begin
            chk({tag, ".StallCnt"}, 32'(hz.StallCnt), 32'(sc));
            chk({tag, ".FlushCnt"}, 32'(hz.FlushCnt), 32'(fc));
        end
    endtask

    typedef struct {
        bit r, v; logic [3:0] a1, a2, w; bit rw, ld, pcs, bt;
        bit sf, sd, fd, fe; int fa, fb, sc, fc;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit r, input bit v, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] w, input bit rw, input bit ld, input bit pcs,
                       input bit bt, input bit sf, input bit sd, input bit fd, input bit fe,
                       input int fa, input int fb, input int sc, input int fc);
        tbl.push_back('{r, v, a1, a2, w, rw, ld, pcs, bt, sf, sd, fd, fe, fa, fb, sc, fc});
    endtask

    function automatic logic [3:0] rnd_reg();
        int k;
        k = int'($urandom_range(0, 5));
        case (k)
            0, 1, 2, 3: return 4'(k);
            4:          return 4'd15;
            default:    return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        out_t o;
        c_rst = 0; c_v = 0; c_ra1 = 0; c_ra2 = 0; c_wa = 0;
        c_rw = 0; c_ld = 0; c_pcs = 0; c_bt = 0;
        reset = 0; hz.ValidD = 0; hz.Ra1D = 0; hz.Ra2D = 0; hz.WA3D = 0;
        hz.RegWriteD = 0; hz.MemtoRegD = 0; hz.PCSrcD = 0; hz.BranchTakenE = 0;

        // reset low 3 cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            apply(0, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            check_all($sformatf("rst%0d", i), 0, 0, 0, 0, 0, 0, i > 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            check_all($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 0);
        end

        // r  v  a1 a2 wa rw ld pcs bt | sf sd fd fe fa fb sc fc
        add(1, 1, 3, 4, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // ADD R1
        add(1, 1, 1, 5, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // SUB uses R1
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0, 0); // SUB in E: from M
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 2, 3, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // ADD R1
        add(1, 1, 7, 8, 9, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // filler
        add(1, 1, 1, 1, 2, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // SUB R1,R1
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0); // from W
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 3, 4, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // LDR R2
        add(1, 1, 5, 2, 6, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0); // ADD uses R2: stall
        add(1, 1, 5, 2, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1); // ADD held, E bubble
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 1); // ADD in E: from W
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        add(1, 1, 3, 4, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1); // LDR R2
        add(1, 1, 5, 2, 6, 1, 0, 0, 1,  0, 0, 1, 1, 0, 0, 1, 1); // load-use + taken branch
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2);
        add(1, 1, 3, 4, 15, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 2); // MOV PC
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2); // PC write in W
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2);
        add(1, 1, 3, 4, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2); // LDR R2
        add(0, 1, 5, 2, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2); // reset during stall
        add(1, 1, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // write R15
        add(1, 1, 15, 15, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // read R15
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // PC never forwarded
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // load into R15
        add(1, 1, 15, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // no load-use on PC

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].a1, tbl[i].a2, tbl[i].w, tbl[i].rw,
                  tbl[i].ld, tbl[i].pcs, tbl[i].bt);
            check_all($sformatf("vec%0d", i), tbl[i].sf, tbl[i].sd, tbl[i].fd, tbl[i].fe,
                      tbl[i].fa, tbl[i].fb, 1, tbl[i].sc, tbl[i].fc);
        end

        // FlushCnt saturates rather than wrapping
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < SAT + 3; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("sat%0d.FlushCnt", i), 32'(hz.FlushCnt), 32'((i < SAT) ? i : SAT));
        end
        idle();
        chk("sat.FlushCnt", 32'(hz.FlushCnt), 32'(SAT));
        chk("sat.StallCnt", 32'(hz.StallCnt), 32'(0));

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            apply($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, rnd_reg(), rnd_reg(),
                  rnd_reg(), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
            o = model_out();
            check_all($sformatf("rnd%0d", i), o.sf, o.sd, o.fd, o.fe, o.fa, o.fb,
                      1, m_scnt, m_fcnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
